// File: rtl/poly_ram_streamer.sv
// Streams a contiguous, wrapping run of RAM words out as a valid/ready stream,
// hiding the RAM's one-cycle registered read latency behind a 2-entry FIFO.
module poly_ram_streamer #(
    parameter int WIDTH  = 96,
    parameter int LENGTH = 1024,
    parameter int ADDR_W = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WIDTH-1:0]  ram_dout,
    output logic              m_valid,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ZERO} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] addr;
    logic              inflight;
    logic              inflight_last;
    logic [WIDTH-1:0]  fifo_data [2];
    logic [1:0]        fifo_last;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;
    logic              issue;
    logic              issue_last;
    logic              done_next;
    logic [2:0]        occupancy;

    assign pop        = m_valid & m_ready;
    assign push       = inflight;
    // Words buffered or in flight once this cycle's pop is taken out.
    assign occupancy  = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue_last = (remaining == {{ADDR_W{1'b0}}, 1'b1});

    assign busy     = (state != IDLE);
    assign ram_en   = issue;
    assign ram_addr = addr;
    assign m_valid  = (count != 2'd0);
    assign m_data   = fifo_data[rd_ptr];
    assign m_last   = fifo_last[rd_ptr] & m_valid;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words != '0) ? ISSUE : ZERO;
                end
            end
            ISSUE: begin
                if (occupancy < 3'd2) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Zero occupancy here means the final beat is handshaking now.
                if (occupancy == 3'd0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            ZERO: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
            count         <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_last     <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            done <= done_next;
            if (state == IDLE && start) begin
                addr      <= base_addr;
                remaining <= num_words;
            end else if (issue) begin
                addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            inflight      <= issue;
            inflight_last <= issue & issue_last;
            if (push) begin
                fifo_data[wr_ptr] <= ram_dout;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
